// File: rtl/latch_word_serializer.sv
// Parallel-in, serial-out reader for a latched word: captures D on an accepted LOAD,
// shifts it out one bit per clock with SO_VALID, then pulses DONE and returns to idle.
module latch_word_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             CLK,
   input  logic             RST_n,
   input  logic [WIDTH-1:0] D,
   input  logic             LOAD,
   output logic             READY,
   output logic             SO,
   output logic             SO_VALID,
   output logic             DONE
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_FIN   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q <= S_IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
      end
   end

   // LOAD is only looked at in IDLE, so requests during a word in flight are dropped.
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (LOAD) begin
               sr_d    = D;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            sr_d = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = S_FIN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign READY    = (state_q == S_IDLE);
   assign SO_VALID = (state_q == S_SHIFT);
   assign DONE     = (state_q == S_FIN);
   assign SO       = SO_VALID & (MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0]);

endmodule
